// File: rtl/hsid_pkg.sv
// Shared types and default sizing for the HSID main controller slice.
// States of the lane controller plus word/band/library/lane defaults.
package hsid_pkg;

    localparam int HSID_WORD_WIDTH        = 32;
    localparam int HSID_HSP_BANDS_WIDTH   = 8;
    localparam int HSID_HSP_LIBRARY_WIDTH = 8;
    localparam int HSID_BANDS_PER_PACK    = 2;
    localparam int HSID_NUM_LANES         = 4;

    typedef enum logic [2:0] {
        HL_IDLE,
        HL_CONFIG,
        HL_READ_CAPTURED,
        HL_COMPUTE,
        HL_WAIT_MSE,
        HL_DONE,
        HL_CLEAR,
        HL_ERROR
    } hsid_lane_state_t;

endpackage

// File: rtl/hsid_credit_counter.sv
// Saturating up/down counter of MSE results still owed by the lanes.
// Simultaneous inc/dec leaves the count unchanged; dec at zero is ignored.
module hsid_credit_counter
    import hsid_pkg::*;
#(
    parameter int MAX_COUNT = HSID_NUM_LANES,
    parameter int CNT_W     = $clog2(MAX_COUNT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(MAX_COUNT);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    assign full  = (count_reg == MAX_VAL);
    assign empty = (count_reg == '0);
    assign count = count_reg;

    always_comb begin
        count_next = count_reg;
        if (inc && !dec && !full) begin
            count_next = count_reg + 1'b1;
        end else if (dec && !inc && !empty) begin
            count_next = count_reg - 1'b1;
        end else if (inc && dec && empty) begin
            // nothing to retire, so only the new claim counts
            count_next = count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/hsid_main_lane_ctrl.sv
// HSID main controller: config, capture, and band-pack streaming to NUM_LANES MSE lanes.
// Optional WAIT_MSE watchdog is built when HSID_MAIN_TIMEOUT_EN is defined.
module hsid_main_lane_ctrl
    import hsid_pkg::*;
#(
    parameter int WORD_WIDTH        = HSID_WORD_WIDTH,
    parameter int HSP_BANDS_WIDTH   = HSID_HSP_BANDS_WIDTH,
    parameter int HSP_LIBRARY_WIDTH = HSID_HSP_LIBRARY_WIDTH,
    parameter int BANDS_PER_PACK    = HSID_BANDS_PER_PACK,
    parameter int NUM_LANES         = HSID_NUM_LANES,
    parameter int TIMEOUT_CYCLES    = 256,
    localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         clear,
    input  logic [HSP_BANDS_WIDTH-1:0]   hsp_bands,
    input  logic [HSP_LIBRARY_WIDTH-1:0] hsp_library_size,
    input  logic                         fifo_captured_complete,
    input  logic                         fifo_ref_empty,
    input  logic                         mse_valid,
    output logic                         fifo_both_read_en,
    output logic                         band_pack_valid,
    output logic                         band_pack_start,
    output logic                         band_pack_last,
    output logic [LANE_W-1:0]            lane_sel,
    output logic [HSP_LIBRARY_WIDTH-1:0] hsp_ref_count,
    output logic                         initialize,
    output logic                         idle,
    output logic                         ready,
    output logic                         done,
    output logic                         error
);

    localparam int CNT_W     = $clog2(NUM_LANES + 1);
    localparam int BPP_SHIFT = $clog2(BANDS_PER_PACK);
    localparam int BRW       = HSP_BANDS_WIDTH + 1;

    hsid_lane_state_t state_reg, state_next;

    logic [HSP_BANDS_WIDTH-1:0]   cfg_bands_reg;
    logic [HSP_LIBRARY_WIDTH-1:0] cfg_lib_size_reg;
    logic [HSP_BANDS_WIDTH-1:0]   cfg_threshold;
    logic [BRW-1:0]               bands_round;
    logic [HSP_BANDS_WIDTH-1:0]   pack_count_reg;
    logic [HSP_BANDS_WIDTH-1:0]   rd_pack_reg;
    logic [HSP_LIBRARY_WIDTH-1:0] rd_ref_reg;
    logic [HSP_LIBRARY_WIDTH-1:0] hsp_ref_count_reg;
    logic                         valid_reg;
    logic [CNT_W-1:0]             outstanding;
    logic                         cred_full, cred_empty;
    logic                         in_compute, pack_valid, pack_last, last_ref;
    logic                         stall, read_en, timeout_hit;

    assign bands_round   = {1'b0, cfg_bands_reg} + BRW'(BANDS_PER_PACK - 1);
    assign cfg_threshold = HSP_BANDS_WIDTH'(bands_round >> BPP_SHIFT);

    assign in_compute = (state_reg == HL_COMPUTE);
    assign pack_valid = valid_reg && in_compute;
    assign pack_last  = pack_valid && (pack_count_reg == cfg_threshold - 1'b1);
    assign last_ref   = (hsp_ref_count_reg == cfg_lib_size_reg - 1'b1);

    // Reads run one cycle ahead of the pack qualifiers, so a last pack still
    // in flight already holds the lane it is about to claim.
    assign stall   = (rd_pack_reg == '0) &&
                     (cred_full || (pack_last && outstanding == CNT_W'(NUM_LANES - 1)));
    assign read_en = in_compute && !fifo_ref_empty && !stall && (rd_ref_reg != cfg_lib_size_reg);

    assign fifo_both_read_en = read_en;
    assign band_pack_valid   = pack_valid;
    assign band_pack_start   = pack_valid && (pack_count_reg == '0);
    assign band_pack_last    = pack_last;
    assign hsp_ref_count     = hsp_ref_count_reg;
    assign initialize        = (state_reg == HL_DONE) || (state_reg == HL_CLEAR) ||
                               (state_reg == HL_ERROR);
    assign idle              = (state_reg == HL_IDLE);
    assign ready             = (state_reg == HL_READ_CAPTURED) || in_compute;
    assign done              = (state_reg == HL_DONE);
    assign error             = (state_reg == HL_ERROR);

    generate
        if (NUM_LANES > 1) begin : g_lane_multi
            assign lane_sel = hsp_ref_count_reg[LANE_W-1:0];
        end else begin : g_lane_single
            assign lane_sel = 1'b0;
        end
    endgenerate

    hsid_credit_counter #(
        .MAX_COUNT (NUM_LANES),
        .CNT_W     (CNT_W)
    ) u_credit (
        .clk   (clk),
        .rst   (rst),
        .clr   (initialize),
        .inc   (pack_last),
        .dec   (mse_valid),
        .count (outstanding),
        .full  (cred_full),
        .empty (cred_empty)
    );

`ifdef HSID_MAIN_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_count_reg <= '0;
        end else if (state_reg != HL_WAIT_MSE || mse_valid) begin
            to_count_reg <= '0;
        end else begin
            to_count_reg <= to_count_reg + 1'b1;
        end
    end

    assign timeout_hit = ((state_reg == HL_WAIT_MSE) && !mse_valid &&
                          (to_count_reg == TO_W'(TIMEOUT_CYCLES - 1))) || (WORD_WIDTH < 0);
`else
    // WORD_WIDTH and TIMEOUT_CYCLES carry no logic in this build
    assign timeout_hit = (TIMEOUT_CYCLES < 0) || (WORD_WIDTH < 0);
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            HL_IDLE:          if (start) state_next = HL_CONFIG;
            HL_CONFIG:        state_next = (hsp_bands == '0 || hsp_library_size == '0) ?
                                           HL_ERROR : HL_READ_CAPTURED;
            HL_READ_CAPTURED: if (fifo_captured_complete) state_next = HL_COMPUTE;
            HL_COMPUTE:       if (pack_last && last_ref) state_next = HL_WAIT_MSE;
            HL_WAIT_MSE: begin
                if (cred_empty) state_next = HL_DONE;
                else if (timeout_hit) state_next = HL_ERROR;
            end
            default:          state_next = HL_IDLE;
        endcase
        if (clear && (state_reg == HL_CONFIG || state_reg == HL_READ_CAPTURED ||
                      in_compute || state_reg == HL_WAIT_MSE)) begin
            state_next = HL_CLEAR;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= HL_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_bands_reg     <= '1;
            cfg_lib_size_reg  <= '1;
            pack_count_reg    <= '0;
            rd_pack_reg       <= '0;
            rd_ref_reg        <= '0;
            hsp_ref_count_reg <= '0;
            valid_reg         <= 1'b0;
        end else begin
            valid_reg <= read_en;
            if (initialize) begin
                cfg_bands_reg     <= '1;
                cfg_lib_size_reg  <= '1;
                pack_count_reg    <= '0;
                rd_pack_reg       <= '0;
                rd_ref_reg        <= '0;
                hsp_ref_count_reg <= '0;
            end else begin
                if (state_reg == HL_CONFIG) begin
                    cfg_bands_reg    <= hsp_bands;
                    cfg_lib_size_reg <= hsp_library_size;
                end
                if (read_en) begin
                    if (rd_pack_reg == cfg_threshold - 1'b1) begin
                        rd_pack_reg <= '0;
                        rd_ref_reg  <= rd_ref_reg + 1'b1;
                    end else begin
                        rd_pack_reg <= rd_pack_reg + 1'b1;
                    end
                end
                if (pack_valid) begin
                    pack_count_reg <= pack_last ? '0 : pack_count_reg + 1'b1;
                end
                if (pack_last) begin
                    hsp_ref_count_reg <= hsp_ref_count_reg + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_hsid_main_lane_ctrl.sv
// Directed bench for hsid_main_lane_ctrl: a 4-lane and a 2-lane instance share stimulus.
// Define HSID_MAIN_TIMEOUT_EN to also exercise the WAIT_MSE watchdog.
module tb_hsid_main_lane_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, clear = 1'b0;
    logic [7:0] hsp_bands = '0, hsp_library_size = '0;
    logic       fifo_captured_complete = 1'b0, fifo_ref_empty = 1'b0, mse_valid = 1'b0;

    logic       a_rd, a_valid, a_start, a_last, a_init, a_idle, a_ready, a_done, a_error;
    logic [1:0] a_lane;
    logic [7:0] a_ref;
    logic       b_rd, b_valid, b_start, b_last, b_init, b_idle, b_ready, b_done, b_error;
    logic [0:0] b_lane;
    logic [7:0] b_ref;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hsid_main_lane_ctrl #(.NUM_LANES(4), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .start(start), .clear(clear),
        .hsp_bands(hsp_bands), .hsp_library_size(hsp_library_size),
        .fifo_captured_complete(fifo_captured_complete), .fifo_ref_empty(fifo_ref_empty),
        .mse_valid(mse_valid), .fifo_both_read_en(a_rd), .band_pack_valid(a_valid),
        .band_pack_start(a_start), .band_pack_last(a_last), .lane_sel(a_lane),
        .hsp_ref_count(a_ref), .initialize(a_init), .idle(a_idle), .ready(a_ready),
        .done(a_done), .error(a_error)
    );

    hsid_main_lane_ctrl #(.NUM_LANES(2), .TIMEOUT_CYCLES(16)) dut2 (
        .clk(clk), .rst(rst), .start(start), .clear(clear),
        .hsp_bands(hsp_bands), .hsp_library_size(hsp_library_size),
        .fifo_captured_complete(fifo_captured_complete), .fifo_ref_empty(fifo_ref_empty),
        .mse_valid(mse_valid), .fifo_both_read_en(b_rd), .band_pack_valid(b_valid),
        .band_pack_start(b_start), .band_pack_last(b_last), .lane_sel(b_lane),
        .hsp_ref_count(b_ref), .initialize(b_init), .idle(b_idle), .ready(b_ready),
        .done(b_done), .error(b_error)
    );

    task automatic kick(input logic [7:0] bands, input logic [7:0] lib);
        @(negedge clk);
        hsp_bands = bands; hsp_library_size = lib; fifo_captured_complete = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        $display("run bands=%0d lib=%0d", bands, lib);
    endtask

    task automatic cleanup;
        @(negedge clk);
        mse_valid = 1'b0; fifo_ref_empty = 1'b0; clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_vec++;
        if (a_idle !== 1'b1 || {a_ready, a_done, a_error, a_init, a_valid, a_rd} !== 6'b0) begin
            n_err++; $display("FAIL reset_status got idle=%b others=%b want idle=1 others=000000",
                              a_idle, {a_ready, a_done, a_error, a_init, a_valid, a_rd});
        end
        n_vec++;
        if (a_ref !== 8'd0 || a_lane !== 2'd0) begin
            n_err++; $display("FAIL reset_counters got ref=%0d lane=%0d want 0 0", a_ref, a_lane);
        end
        n_vec++;
        if (dut.cfg_bands_reg !== 8'hFF || dut.cfg_lib_size_reg !== 8'hFF) begin
            n_err++; $display("FAIL reset_cfg got %h %h want ff ff", dut.cfg_bands_reg, dut.cfg_lib_size_reg);
        end
        $display("reset checked");
    endtask

    task automatic test_stream;
        int k = 0;
        int reads = 0;
        bit seen_done = 0;
        kick(8'd5, 8'd3);
        for (int cyc = 0; cyc < 80 && k < 9; cyc++) begin
            @(negedge clk);
            n_vec++;
            if (a_rd && fifo_ref_empty) begin
                n_err++; $display("FAIL read_when_empty got rd=1 want rd=0 cyc=%0d", cyc);
            end
            if (a_rd) reads++;
            if (a_valid) begin
                n_vec++;
                if (a_start !== (k % 3 == 0) || a_last !== (k % 3 == 2) ||
                    a_lane !== 2'(k / 3) || a_ref !== 8'(k / 3) || a_ready !== 1'b1) begin
                    n_err++; $display("FAIL stream_pack%0d got s=%b l=%b lane=%0d ref=%0d rdy=%b want s=%b l=%b lane=%0d ref=%0d rdy=1",
                                      k, a_start, a_last, a_lane, a_ref, a_ready,
                                      k % 3 == 0, k % 3 == 2, k / 3, k / 3);
                end
                $display("pack %0d start=%b last=%b lane=%0d ref=%0d", k, a_start, a_last, a_lane, a_ref);
                k++;
            end
            fifo_ref_empty = (cyc % 3 == 1);
        end
        fifo_ref_empty = 1'b0;
        n_vec++;
        if (k != 9) begin
            n_err++; $display("FAIL stream_pack_count got %0d want 9", k);
        end
        mse_valid = 1'b1;
        repeat (3) @(negedge clk);
        mse_valid = 1'b0;
        for (int cyc = 0; cyc < 10 && !seen_done; cyc++) begin
            @(negedge clk);
            if (a_rd) reads++;
            if (a_done) begin
                seen_done = 1;
                n_vec++;
                if (a_init !== 1'b1 || a_ready !== 1'b0 || a_error !== 1'b0) begin
                    n_err++; $display("FAIL stream_done_status got init=%b rdy=%b err=%b want 1 0 0",
                                      a_init, a_ready, a_error);
                end
            end
        end
        n_vec++;
        if (!seen_done) begin
            n_err++; $display("FAIL stream_done got none want done within 10 cycles");
        end
        @(negedge clk);
        n_vec++;
        if (a_idle !== 1'b1 || a_done !== 1'b0 || a_ref !== 8'd0) begin
            n_err++; $display("FAIL stream_back_idle got idle=%b done=%b ref=%0d want 1 0 0", a_idle, a_done, a_ref);
        end
        n_vec++;
        if (reads != 9) begin
            n_err++; $display("FAIL stream_reads got %0d want 9", reads);
        end
        cleanup();
    endtask

    task automatic test_stall;
        int k = 0;
        int bad = 0;
        bit resumed = 0;
        kick(8'd4, 8'd4);
        for (int cyc = 0; cyc < 40 && k < 4; cyc++) begin
            @(negedge clk);
            if (b_valid) begin
                n_vec++;
                if (b_start !== (k % 2 == 0) || b_last !== (k % 2 == 1) || b_ref !== 8'(k / 2)) begin
                    n_err++; $display("FAIL stall_pack%0d got s=%b l=%b ref=%0d want s=%b l=%b ref=%0d",
                                      k, b_start, b_last, b_ref, k % 2 == 0, k % 2 == 1, k / 2);
                end
                k++;
            end
        end
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (b_valid || b_rd || dut2.pack_count_reg != 8'd0) bad++;
        end
        n_vec++;
        if (bad != 0 || b_ref !== 8'd2) begin
            n_err++; $display("FAIL stall_hold got bad_cycles=%0d ref=%0d want 0 2", bad, b_ref);
        end
        $display("stall held at ref %0d", b_ref);
        mse_valid = 1'b1;
        @(negedge clk);
        mse_valid = 1'b0;
        for (int cyc = 0; cyc < 10 && !resumed; cyc++) begin
            @(negedge clk);
            if (b_valid) begin
                resumed = 1;
                n_vec++;
                if (b_start !== 1'b1 || b_lane !== 1'b0 || b_ref !== 8'd2) begin
                    n_err++; $display("FAIL stall_resume got s=%b lane=%0d ref=%0d want 1 0 2", b_start, b_lane, b_ref);
                end
            end
        end
        n_vec++;
        if (!resumed) begin
            n_err++; $display("FAIL stall_resume_seen got none want pack within 10 cycles");
        end
        cleanup();
    endtask

    task automatic test_single_pack;
        int k = 0;
        bit seen_done = 0;
        kick(8'd1, 8'd3);
        for (int cyc = 0; cyc < 40 && k < 3; cyc++) begin
            @(negedge clk);
            if (a_valid) begin
                n_vec++;
                if (a_start !== 1'b1 || a_last !== 1'b1 || a_ref !== 8'(k) || a_lane !== 2'(k)) begin
                    n_err++; $display("FAIL single_pack%0d got s=%b l=%b ref=%0d lane=%0d want 1 1 %0d %0d",
                                      k, a_start, a_last, a_ref, a_lane, k, k);
                end
                k++;
            end
        end
        n_vec++;
        if (k != 3) begin
            n_err++; $display("FAIL single_pack_count got %0d want 3", k);
        end
        mse_valid = 1'b1;
        repeat (3) @(negedge clk);
        mse_valid = 1'b0;
        for (int cyc = 0; cyc < 10 && !seen_done; cyc++) begin
            @(negedge clk);
            if (a_done) seen_done = 1;
        end
        n_vec++;
        if (!seen_done) begin
            n_err++; $display("FAIL single_done got none want done within 10 cycles");
        end
        cleanup();
    endtask

    task automatic test_config_error;
        logic [7:0] bands_tab [2] = '{8'd0, 8'd2};
        logic [7:0] lib_tab   [2] = '{8'd3, 8'd0};
        for (int t = 0; t < 2; t++) begin
            kick(bands_tab[t], lib_tab[t]);
            n_vec++;
            if (a_idle !== 1'b0 || a_error !== 1'b0 || a_ready !== 1'b0) begin
                n_err++; $display("FAIL cfgerr%0d_config got idle=%b err=%b rdy=%b want 0 0 0", t, a_idle, a_error, a_ready);
            end
            @(negedge clk);
            n_vec++;
            if (a_error !== 1'b1 || a_init !== 1'b1 || b_error !== 1'b1) begin
                n_err++; $display("FAIL cfgerr%0d_error got err=%b init=%b err2=%b want 1 1 1", t, a_error, a_init, b_error);
            end
            @(negedge clk);
            n_vec++;
            if (a_idle !== 1'b1 || a_error !== 1'b0 || a_init !== 1'b0) begin
                n_err++; $display("FAIL cfgerr%0d_idle got idle=%b err=%b init=%b want 1 0 0", t, a_idle, a_error, a_init);
            end
        end
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        n_vec++;
        if (a_idle !== 1'b1 || a_init !== 1'b0) begin
            n_err++; $display("FAIL clear_in_idle got idle=%b init=%b want 1 0", a_idle, a_init);
        end
        cleanup();
    endtask

    task automatic test_clear_mid;
        int k = 0;
        bit hit = 0;
        kick(8'd5, 8'd4);
        for (int cyc = 0; cyc < 60 && !hit; cyc++) begin
            @(negedge clk);
            if (a_valid) begin
                if (k == 7) begin
                    hit = 1;
                    n_vec++;
                    if (a_ref !== 8'd2 || a_start !== 1'b0 || a_last !== 1'b0) begin
                        n_err++; $display("FAIL clear_point got ref=%0d s=%b l=%b want 2 0 0", a_ref, a_start, a_last);
                    end
                    clear = 1'b1;
                end
                k++;
            end
        end
        n_vec++;
        if (!hit) begin
            n_err++; $display("FAIL clear_point_seen got %0d packs want 8", k);
        end
        @(negedge clk);
        clear = 1'b0;
        n_vec++;
        if (a_init !== 1'b1 || a_idle !== 1'b0 || a_valid !== 1'b0 || a_ready !== 1'b0) begin
            n_err++; $display("FAIL clear_state got init=%b idle=%b valid=%b rdy=%b want 1 0 0 0",
                              a_init, a_idle, a_valid, a_ready);
        end
        @(negedge clk);
        n_vec++;
        if (a_idle !== 1'b1 || a_ref !== 8'd0 || dut.pack_count_reg !== 8'd0 ||
            dut.cfg_bands_reg !== 8'hFF || dut.cfg_lib_size_reg !== 8'hFF) begin
            n_err++; $display("FAIL clear_restore got idle=%b ref=%0d pc=%0d cfg=%h/%h want 1 0 0 ff/ff",
                              a_idle, a_ref, dut.pack_count_reg, dut.cfg_bands_reg, dut.cfg_lib_size_reg);
        end
        $display("clear mid-compute done");
        cleanup();
    endtask

`ifdef HSID_MAIN_TIMEOUT_EN
    task automatic test_timeout;
        int k = 0;
        bit fired = 0;
        kick(8'd3, 8'd2);
        for (int cyc = 0; cyc < 40 && k < 4; cyc++) begin
            @(negedge clk);
            mse_valid = 1'b0;
            if (a_valid) begin
                if (k == 2) mse_valid = 1'b1;
                k++;
            end
        end
        mse_valid = 1'b0;
        n_vec++;
        if (k != 4) begin
            n_err++; $display("FAIL timeout_packs got %0d want 4", k);
        end
        for (int cyc = 1; cyc <= 17; cyc++) begin
            @(negedge clk);
            if (cyc == 16) begin
                n_vec++;
                if (a_error !== 1'b0) begin
                    n_err++; $display("FAIL timeout_early got err=%b want 0", a_error);
                end
            end
            if (cyc == 17) begin
                fired = a_error && a_init;
            end
        end
        n_vec++;
        if (!fired) begin
            n_err++; $display("FAIL timeout_fire got err=%b init=%b want 1 1", a_error, a_init);
        end
        cleanup();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_stream();
        test_stall();
        test_single_pack();
        test_config_error();
        test_clear_mid();
`ifdef HSID_MAIN_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
